// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 mul/div sequencer owning HI/LO; W+1 cycles start-to-done (1 cycle for divide-by-zero).
// No backpressure input: stall_req holds the front of the pipeline while an op is in flight or HI/LO would be raced.
module muldiv_ctrl #(
   parameter int W         = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_mul,
   input  logic         start_div,
   input  logic         is_signed,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         mf_req,
   input  logic         mt_hi,
   input  logic         mt_lo,
   input  logic         flush,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         busy,
   output logic         done,
   output logic         stall_req
);
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [2*W-1:0]   p_q, p_d;
   logic             sgn_q, sgn_d, div_q, div_d, done_q, done_d;

   logic             start, accept, sgn_in;
   logic [W-1:0]     mag_a, mag_b;
   logic [W:0]       mul_sum, div_sh, div_diff;
   logic [2*W-1:0]   prod;
   logic [W-1:0]     quo, rem;

   function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
      return (s && x[W-1]) ? (~x + W'(1)) : x;
   endfunction

   assign start  = start_mul | start_div;
   assign accept = (state_q == IDLE) && start && !flush;
   assign sgn_in = is_signed & SIGNED_EN;
   assign mag_a  = mag(a_q, sgn_q);
   assign mag_b  = mag(b_q, sgn_q);

   // p holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
   assign mul_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, mag_a} : '0);
   assign div_sh   = {p_q[2*W-1:W], p_q[W-1]};
   assign div_diff = div_sh - {1'b0, mag_b};

   assign prod = (sgn_q && (a_q[W-1] ^ b_q[W-1])) ? (~p_q + (2*W)'(1)) : p_q;
   assign quo  = (sgn_q && (a_q[W-1] ^ b_q[W-1])) ? (~p_q[W-1:0] + W'(1)) : p_q[W-1:0];
   assign rem  = (sgn_q && a_q[W-1]) ? (~p_q[2*W-1:W] + W'(1)) : p_q[2*W-1:W];

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      p_d     = p_q;
      sgn_d   = sgn_q;
      div_d   = div_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = op_a;
               b_d     = op_b;
               sgn_d   = sgn_in;
               div_d   = !start_mul;
               count_d = CW'(W);
               if (start_mul) begin
                  p_d     = {{W{1'b0}}, mag(op_b, sgn_in)};
                  state_d = MUL;
               end else begin
                  p_d     = {{W{1'b0}}, mag(op_a, sgn_in)};
                  state_d = (op_b == '0) ? FIX : DIV;
               end
            end else if (!start) begin
               if (mt_hi) hi_d = op_a;
               if (mt_lo) lo_d = op_a;
            end
         end
         MUL: begin
            p_d     = {mul_sum, p_q[W-1:1]};
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = FIX;
         end
         DIV: begin
            if (!div_diff[W]) p_d = {div_diff[W-1:0], p_q[W-2:0], 1'b1};
            else              p_d = {p_q[2*W-2:0], 1'b0};
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (!div_q) begin
                  hi_d = prod[2*W-1:W];
                  lo_d = prod[W-1:0];
               end else if (b_q == '0) begin
                  hi_d = a_q;
                  lo_d = {W{1'b1}};
               end else begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         p_q     <= '0;
         sgn_q   <= 1'b0;
         div_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         p_q     <= p_d;
         sgn_q   <= sgn_d;
         div_q   <= div_d;
         done_q  <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign stall_req = !rst && ((start && busy) ||
                               (mf_req && (busy || start)) ||
                               ((mt_hi | mt_lo) && busy));
endmodule
